// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: funct codes, FSM states and
// the width helper used to size shift amounts and step counters.
package alu_pkg;

    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle datapath: AND/OR/ADD/SUB/SLT/SRL, carry and
// overflow flags, and decode of unsupported funct codes.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             illegal
);

    localparam int SHW = clog2(WIDTH);

    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             c_msb;
    logic             add_ovf;
    logic             slt_bit;

    // B is inverted (with carry-in 1) for every code except ADD.
    assign sub_mode = (funct != FN_ADD);
    assign b_eff    = sub_mode ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    // Carry into the MSB recovered from the MSB sum bit and its two inputs.
    assign c_msb    = sum[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
    assign add_ovf  = c_msb ^ sum[WIDTH];
    assign slt_bit  = sum[WIDTH-1] ^ add_ovf;

    // Result and flag selection by funct code.
    always_comb begin
        result  = '0;
        cout    = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (funct)
            FN_AND:   result = a & b;
            FN_OR:    result = a | b;
            FN_ADD, FN_SUB: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
                ovf    = add_ovf;
            end
            FN_SLT: begin
                result = {{(WIDTH-1){1'b0}}, slt_bit};
                cout   = sum[WIDTH];
            end
            FN_SRL:   result = a >> b[SHW-1:0];
            FN_MULTU: result = '0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: registers single-cycle results from alu_comb and runs
// a radix-2 shift-add unsigned multiply with a start/busy/done handshake.
//
// state | meaning
// IDLE  | accepting start; single-cycle ops complete here
// MUL   | one shift-add step per cycle, busy high, start ignored
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] hiOut,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             illegal
);

    localparam int CW = clog2(WIDTH) + 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

    state_t             state_q,   state_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [WIDTH-1:0]   dout_q,    dout_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic               cout_q,    cout_d;
    logic               ovf_q,     ovf_d;
    logic               zero_q,    zero_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    // Upper half accumulates partial sums; the multiplier is loaded into the
    // lower half and retires one bit per step as product bits shift in.
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [CW-1:0]      count_q,   count_d;

    logic [WIDTH-1:0]   c_result;
    logic               c_cout;
    logic               c_ovf;
    logic               c_illegal;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] step_acc;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .funct   (Signal),
        .a       (dataA),
        .b       (dataB),
        .result  (c_result),
        .cout    (c_cout),
        .ovf     (c_ovf),
        .illegal (c_illegal)
    );

    // Dedicated WIDTH+1-bit multiply adder, then shift {carry, acc} right.
    always_comb begin
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
        step_acc = {step_sum, acc_q[WIDTH-1:1]};
    end

    // Next-state logic for the FSM, multiplier and result registers.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dout_d    = dout_q;
        hi_d      = hi_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (Signal == FN_MULTU) begin
                        mcand_d = dataA;
                        acc_d   = {{WIDTH{1'b0}}, dataB};
                        count_d = COUNT_INIT;
                        busy_d  = 1'b1;
                        state_d = MUL;
                    end else begin
                        dout_d    = c_result;
                        hi_d      = '0;
                        cout_d    = c_cout;
                        ovf_d     = c_ovf;
                        illegal_d = c_illegal;
                        zero_d    = (c_result == '0);
                        done_d    = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d   = step_acc;
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    dout_d    = step_acc[WIDTH-1:0];
                    hi_d      = step_acc[2*WIDTH-1:WIDTH];
                    cout_d    = 1'b0;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    zero_d    = (step_acc == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            hi_q      <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
            hi_q      <= hi_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dataOut = dout_q;
    assign hiOut   = hi_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;

    localparam int W = 32;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   sig;
    logic [W-1:0] dA, dB;
    logic         busy, done, cout, ovf, zero, illegal;
    logic [W-1:0] dataOut, hiOut;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Signal  (sig),
        .dataA   (dA),
        .dataB   (dB),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut),
        .hiOut   (hiOut),
        .cout    (cout),
        .ovf     (ovf),
        .zero    (zero),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // flags = {done, busy, cout, ovf, zero, illegal}
    function automatic logic [5:0] flags_now();
        return {done, busy, cout, ovf, zero, illegal};
    endfunction

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; sig = f; dA = a; dB = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sig = '0; dA = '0; dB = '0;
        tick(); tick();
        n_cmp++;
        if (flags_now() !== 6'b000010) begin
            n_bad++; $display("FAIL reset_flags got %b want %b", flags_now(), 6'b000010);
        end
        n_cmp++;
        if ({dataOut, hiOut} !== 64'h0) begin
            n_bad++; $display("FAIL reset_data got %h want %h", {dataOut, hiOut}, 64'h0);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_add();
        issue(F_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        n_cmp++;
        if (dataOut !== 32'h0 || flags_now() !== 6'b101010) begin
            n_bad++; $display("FAIL add_wrap got %h/%b want %h/%b", dataOut, flags_now(), 32'h0, 6'b101010);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || dataOut !== 32'h0 || cout !== 1'b1) begin
            n_bad++; $display("FAIL add_hold got done=%b %h cout=%b want done=0 0 cout=1", done, dataOut, cout);
        end
        issue(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        n_cmp++;
        if (dataOut !== 32'h8000_0000 || flags_now() !== 6'b100100) begin
            n_bad++; $display("FAIL add_ovf got %h/%b want %h/%b", dataOut, flags_now(), 32'h8000_0000, 6'b100100);
        end
    endtask

    task automatic test_sub_slt();
        issue(F_SUB, 32'h8000_0000, 32'h0000_0001);
        n_cmp++;
        if (dataOut !== 32'h7FFF_FFFF || flags_now() !== 6'b101100) begin
            n_bad++; $display("FAIL sub_ovf got %h/%b want %h/%b", dataOut, flags_now(), 32'h7FFF_FFFF, 6'b101100);
        end
        issue(F_SUB, 32'h0000_0001, 32'h0000_0002);
        n_cmp++;
        if (dataOut !== 32'hFFFF_FFFF || flags_now() !== 6'b100000) begin
            n_bad++; $display("FAIL sub_borrow got %h/%b want %h/%b", dataOut, flags_now(), 32'hFFFF_FFFF, 6'b100000);
        end
        issue(F_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
        n_cmp++;
        if (dataOut !== 32'h1 || flags_now() !== 6'b101000) begin
            n_bad++; $display("FAIL slt_neg got %h/%b want %h/%b", dataOut, flags_now(), 32'h1, 6'b101000);
        end
        issue(F_SLT, 32'h0000_0001, 32'hFFFF_FFFF);
        n_cmp++;
        if (dataOut !== 32'h0 || flags_now() !== 6'b100010) begin
            n_bad++; $display("FAIL slt_pos got %h/%b want %h/%b", dataOut, flags_now(), 32'h0, 6'b100010);
        end
        issue(F_SLT, 32'h8000_0000, 32'h0000_0001);
        n_cmp++;
        if (dataOut !== 32'h1 || flags_now() !== 6'b101000) begin
            n_bad++; $display("FAIL slt_ovf got %h/%b want %h/%b", dataOut, flags_now(), 32'h1, 6'b101000);
        end
    endtask

    task automatic test_logic_shift();
        issue(F_SRL, 32'hF000_0000, 32'h0000_0024);
        n_cmp++;
        if (dataOut !== 32'h0F00_0000 || flags_now() !== 6'b100000) begin
            n_bad++; $display("FAIL srl_4 got %h/%b want %h/%b", dataOut, flags_now(), 32'h0F00_0000, 6'b100000);
        end
        issue(F_SRL, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++;
        if (dataOut !== 32'h0000_0001) begin
            n_bad++; $display("FAIL srl_31 got %h want %h", dataOut, 32'h1);
        end
        issue(F_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        n_cmp++;
        if (dataOut !== 32'hF000_F000 || flags_now() !== 6'b100000) begin
            n_bad++; $display("FAIL and got %h/%b want %h/%b", dataOut, flags_now(), 32'hF000_F000, 6'b100000);
        end
    endtask

    task automatic test_back_to_back();
        issue(F_ADD, 32'h1, 32'h1);
        n_cmp++;
        if (done !== 1'b1 || dataOut !== 32'h2) begin
            n_bad++; $display("FAIL b2b_0 got done=%b %h want done=1 %h", done, dataOut, 32'h2);
        end
        issue(F_SUB, 32'hA, 32'h3);
        n_cmp++;
        if (done !== 1'b1 || dataOut !== 32'h7) begin
            n_bad++; $display("FAIL b2b_1 got done=%b %h want done=1 %h", done, dataOut, 32'h7);
        end
        issue(F_OR, 32'h0000_0F00, 32'h0000_00F0);
        n_cmp++;
        if (done !== 1'b1 || dataOut !== 32'h0000_0FF0) begin
            n_bad++; $display("FAIL b2b_2 got done=%b %h want done=1 %h", done, dataOut, 32'hFF0);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || dataOut !== 32'h0000_0FF0) begin
            n_bad++; $display("FAIL b2b_idle got done=%b %h want done=0 %h", done, dataOut, 32'hFF0);
        end
    endtask

    task automatic test_multu();
        int busy_cnt;
        int done_at;
        issue(F_OR, 32'h0F, 32'hF0);
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        busy_cnt = 0; done_at = -1;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL mul_launch got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        if (busy) busy_cnt++;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge clk);
            if (k == 10) begin start = 1'b1; sig = F_ADD; dA = 32'h1; dB = 32'h1; end
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 11) begin
                n_cmp++;
                if (dataOut !== 32'hFF) begin
                    n_bad++; $display("FAIL mul_hold got %h want %h", dataOut, 32'hFF);
                end
            end
            if (busy) busy_cnt++;
            if (done) done_at = k;
        end
        n_cmp++;
        if (done_at != 32 || busy_cnt != 32) begin
            n_bad++; $display("FAIL mul_latency got done_at=%0d busy=%0d want 32/32", done_at, busy_cnt);
        end
        n_cmp++;
        if (hiOut !== 32'hFFFF_FFFE || dataOut !== 32'h0000_0001 || flags_now() !== 6'b100000) begin
            n_bad++; $display("FAIL mul_max got %h_%h/%b want %h_%h/%b", hiOut, dataOut, flags_now(), 32'hFFFF_FFFE, 32'h1, 6'b100000);
        end
        // start during the done cycle must be accepted
        issue(F_ADD, 32'h2, 32'h3);
        n_cmp++;
        if (done !== 1'b1 || dataOut !== 32'h5 || hiOut !== 32'h0) begin
            n_bad++; $display("FAIL start_on_done got done=%b %h hi=%h want done=1 %h hi=0", done, dataOut, hiOut, 32'h5);
        end
        issue(F_MULTU, 32'h1234_5678, 32'h0000_0010);
        done_at = -1;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            tick();
            if (done) done_at = k;
        end
        n_cmp++;
        if (done_at != 32 || hiOut !== 32'h1 || dataOut !== 32'h2345_6780 || zero !== 1'b0) begin
            n_bad++; $display("FAIL mul_shift got at=%0d %h_%h z=%b want 32 %h_%h z=0", done_at, hiOut, dataOut, zero, 32'h1, 32'h2345_6780);
        end
    endtask

    task automatic test_reset_mid_mul();
        int done_cnt;
        issue(F_MULTU, 32'hFFFF_FFFF, 32'h0000_0003);
        for (int k = 1; k < 16; k++) tick();
        @(negedge clk); reset = 1'b1;
        tick();
        n_cmp++;
        if (flags_now() !== 6'b000010 || dataOut !== 32'h0 || hiOut !== 32'h0) begin
            n_bad++; $display("FAIL reset_mid got %b %h_%h want %b 0_0", flags_now(), hiOut, dataOut, 6'b000010);
        end
        @(negedge clk); reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_bad++; $display("FAIL reset_abort got %0d active cycles want 0", done_cnt);
        end
        issue(F_OR, 32'h0F, 32'hF0);
        n_cmp++;
        if (done !== 1'b1 || dataOut !== 32'hFF) begin
            n_bad++; $display("FAIL after_reset_or got done=%b %h want done=1 %h", done, dataOut, 32'hFF);
        end
    endtask

    task automatic test_illegal();
        issue(F_MULTU, 32'h0000_0002, 32'h8000_0000);
        for (int k = 0; k < 40 && !done; k++) tick();
        issue(6'b111111, 32'h1234_5678, 32'h1);
        n_cmp++;
        if ({done, busy, cout, ovf, illegal} !== 5'b10001 || dataOut !== 32'h0 || hiOut !== 32'h0) begin
            n_bad++; $display("FAIL illegal got %b %h_%h want %b 0_0", {done, busy, cout, ovf, illegal}, hiOut, dataOut, 5'b10001);
        end
        issue(F_ADD, 32'h2, 32'h3);
        n_cmp++;
        if (dataOut !== 32'h5 || flags_now() !== 6'b100000) begin
            n_bad++; $display("FAIL illegal_clear got %h/%b want %h/%b", dataOut, flags_now(), 32'h5, 6'b100000);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_logic_shift();
        test_back_to_back();
        test_multu();
        test_reset_mid_mul();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
